ioctl_upload_bridge: RTL and testbench

//  HPS-facing ioctl upload responder: serves bytes from core memory (cartridge/RAM image) to the
//  HPS when it reads during an upload, the reverse of the ioctl download path that loads CCC files.

---
 rtl/ioctl_upload_bridge_if.sv | 22 ++
 rtl/ioctl_upload_bridge.sv | 100 ++++++++++
 tb/tb_ioctl_upload_bridge.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ioctl_upload_bridge_if.sv
// ioctl_upload_bridge_if: HPS ioctl upload handshake plus memory read port
interface ioctl_upload_bridge_if #(
  parameter int AW = 16
);
  logic          ioctl_upload;
  logic          ioctl_rd;
  logic [15:0]   ioctl_addr;
  logic [7:0]    ioctl_din;
  logic          ioctl_wait;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [7:0]    mem_rdata;
  modport slave (
    input  ioctl_upload, ioctl_rd, ioctl_addr, mem_ack, mem_rdata,
    output ioctl_din, ioctl_wait, mem_req, mem_addr
  );
  modport master (
    output ioctl_upload, ioctl_rd, ioctl_addr, mem_ack, mem_rdata,
    input  ioctl_din, ioctl_wait, mem_req, mem_addr
  );
endinterface

// File: rtl/ioctl_upload_bridge.sv
// ioctl_upload_bridge: serves core memory bytes to the HPS during an ioctl upload, stalling it with ioctl_wait
module ioctl_upload_bridge #(
  parameter int            AW      = 16,
  parameter logic [AW-1:0] BASE    = '0,
  parameter int            SIZE    = 16384,
  parameter logic [7:0]    FILL    = 8'hFF,
  parameter int            TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  ioctl_upload_bridge_if.slave bus,
  output logic        busy,
  output logic        done,
  output logic [16:0] byte_count,
  output logic [7:0]  checksum,
  output logic        err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    din_q, din_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [16:0]   cnt_q, cnt_d, cnt_b;
  logic [7:0]    sum_q, sum_d, sum_b, nb;
  logic          err_q, err_d, pend_q, pend_d, up_q, upd;
  logic          sess_start, rd_ok, in_rng;
  assign busy          = state_q != IDLE;
  assign sess_start    = bus.ioctl_upload & ~up_q;
  assign rd_ok         = bus.ioctl_rd & bus.ioctl_upload & ~busy;
  assign in_rng        = 32'(bus.ioctl_addr) < SIZE;
  assign bus.ioctl_wait = busy | (rd_ok & in_rng);
  assign bus.mem_req   = state_q == REQ;
  assign bus.mem_addr  = addr_q;
  assign bus.ioctl_din = din_q;
  assign done          = ~busy & ~bus.ioctl_upload & pend_q;
  assign byte_count    = cnt_q;
  assign checksum      = sum_q;
  assign err           = err_q;
  // Next-state logic: transfer FSM, timeout counter, session statistics
  always_comb begin
    cnt_b   = sess_start ? '0 : cnt_q;
    sum_b   = sess_start ? '0 : sum_q;
    err_d   = (sess_start ? 1'b0 : err_q) | (bus.ioctl_rd & busy);
    state_d = state_q;
    addr_d  = addr_q;
    tmo_d   = tmo_q;
    upd     = 1'b0;
    nb      = FILL;
    case (state_q)
      IDLE: begin
        if (rd_ok & in_rng) begin
          state_d = REQ;
          addr_d  = BASE + AW'(bus.ioctl_addr);
          tmo_d   = '0;
        end else upd = rd_ok;
      end
      REQ: begin
        if (bus.mem_ack) begin
          upd     = 1'b1;
          nb      = bus.mem_rdata;
          state_d = HOLD;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          upd     = 1'b1;
          err_d   = 1'b1;
          state_d = HOLD;
        end else tmo_d = tmo_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    din_d  = upd ? nb : din_q;
    cnt_d  = (upd & ~&cnt_b) ? cnt_b + 17'd1 : cnt_b;
    sum_d  = upd ? sum_b + nb : sum_b;
    pend_d = bus.ioctl_upload | (pend_q & ~done);
  end
  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      din_q   <= '0;
      tmo_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
      up_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      up_q    <= bus.ioctl_upload;
    end
  end
endmodule

// File: tb/tb_ioctl_upload_bridge.sv
// tb_ioctl_upload_bridge: table-driven and directed checks of the ioctl upload bridge
module tb_ioctl_upload_bridge;
  logic        clk = 1'b0;
  logic        reset;
  logic        busy, done, err;
  logic [16:0] byte_count;
  logic [7:0]  checksum;
  int          n_chk = 0;
  int          n_fail = 0;
  ioctl_upload_bridge_if #(.AW(16)) bus ();
  ioctl_upload_bridge #(.AW(16), .BASE(16'hF000), .SIZE(16384), .FILL(8'hFF), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .done(done),
    .byte_count(byte_count), .checksum(checksum), .err(err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] addr;
    int          d;
    logic [7:0]  rdata;
    logic [7:0]  din;
    int          wc;
    int          rc;
    logic [15:0] ma;
    logic        err;
  } vec_t;
  vec_t v[7];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // One read: ack on REQ cycle index d; returns wait-high cycles, REQ cycles, last mem_addr
  task automatic xfer(input logic [15:0] a, input int d, input logic [7:0] rdat,
                      output int wc, output int rc, output logic [15:0] ma);
    bit fin = 0;
    wc = 0; rc = 0; ma = 16'h0;
    bus.ioctl_rd = 1'b1;
    bus.ioctl_addr = a;
    #1;
    if (bus.ioctl_wait) wc++;
    tick();
    bus.ioctl_rd = 1'b0;
    for (int k = 0; k < 400; k++) begin
      #1;
      if (!bus.ioctl_wait) begin
        fin = 1;
        break;
      end
      wc++;
      if (bus.mem_req) begin
        ma = bus.mem_addr;
        bus.mem_ack = (rc == d);
        bus.mem_rdata = rdat;
        rc++;
      end
      tick();
      bus.mem_ack = 1'b0;
    end
    if (!fin) chk("xfer_bound", 32'(fin), 32'd1);
  endtask
  initial begin
    int wc, rc, dones;
    logic [15:0] ma;
    logic [16:0] m_cnt;
    logic [7:0]  m_sum;
    v[0] = '{16'h0010, 1,    8'hA5, 8'hA5, 4,   2,   16'hF010, 1'b0};
    v[1] = '{16'h2000, 0,    8'h3C, 8'h3C, 3,   1,   16'h1000, 1'b0};
    v[2] = '{16'h3FFF, 3,    8'h81, 8'h81, 6,   4,   16'h2FFF, 1'b0};
    v[3] = '{16'h4000, 0,    8'h00, 8'hFF, 0,   0,   16'h0000, 1'b0};
    v[4] = '{16'hFFFF, 0,    8'h00, 8'hFF, 0,   0,   16'h0000, 1'b0};
    v[5] = '{16'h0001, 254,  8'h5A, 8'h5A, 257, 255, 16'hF001, 1'b0};
    v[6] = '{16'h0002, 1000, 8'h11, 8'hFF, 257, 255, 16'hF002, 1'b1};
    reset = 1'b0;
    bus.ioctl_upload = 1'b0;
    bus.ioctl_rd = 1'b0;
    bus.ioctl_addr = 16'h0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 8'h0;
    tick();
    tick();
    chk("rst_din", 32'(bus.ioctl_din), 32'h0);
    chk("rst_wait", 32'(bus.ioctl_wait), 32'h0);
    chk("rst_req", 32'(bus.mem_req), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_cnt", 32'(byte_count), 32'h0);
    chk("rst_sum", 32'(checksum), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    reset = 1'b1;
    tick();
    bus.ioctl_upload = 1'b1;
    tick();
    m_cnt = 0;
    m_sum = 0;
    for (int i = 0; i < 7; i++) begin
      xfer(v[i].addr, v[i].d, v[i].rdata, wc, rc, ma);
      m_cnt++;
      m_sum += v[i].din;
      chk($sformatf("v%0d_din", i), 32'(bus.ioctl_din), 32'(v[i].din));
      chk($sformatf("v%0d_wait_cycles", i), 32'(wc), 32'(v[i].wc));
      chk($sformatf("v%0d_req_cycles", i), 32'(rc), 32'(v[i].rc));
      if (v[i].rc > 0) chk($sformatf("v%0d_mem_addr", i), 32'(ma), 32'(v[i].ma));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(v[i].err));
      chk($sformatf("v%0d_cnt", i), 32'(byte_count), 32'(m_cnt));
      chk($sformatf("v%0d_sum", i), 32'(checksum), 32'(m_sum));
    end
    bus.ioctl_upload = 1'b0;
    tick();
    tick();
    bus.ioctl_upload = 1'b1;
    tick();
    chk("start_err_clr", 32'(err), 32'h0);
    chk("start_cnt_clr", 32'(byte_count), 32'h0);
    chk("start_sum_clr", 32'(checksum), 32'h0);
    xfer(16'h0010, 0, 8'h01, wc, rc, ma);
    chk("min_lat_wait", 32'(wc), 32'd3);
    xfer(16'h0011, 2, 8'h02, wc, rc, ma);
    xfer(16'h5000, 0, 8'h00, wc, rc, ma);
    chk("sum3_sum", 32'(checksum), 32'h02);
    chk("sum3_cnt", 32'(byte_count), 32'd3);
    bus.ioctl_upload = 1'b0;
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (done) dones++;
      tick();
    end
    chk("sum3_done_pulses", 32'(dones), 32'd1);
    bus.ioctl_upload = 1'b1;
    tick();
    bus.ioctl_rd = 1'b1;
    bus.ioctl_addr = 16'h0020;
    tick();
    bus.ioctl_addr = 16'h0030;
    tick();
    bus.ioctl_rd = 1'b0;
    chk("busy_rd_err", 32'(err), 32'h1);
    chk("busy_rd_addr", 32'(bus.mem_addr), 32'hF020);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 8'h77;
    tick();
    bus.mem_ack = 1'b0;
    tick();
    chk("busy_rd_din", 32'(bus.ioctl_din), 32'h77);
    chk("busy_rd_ignored", 32'(busy), 32'h0);
    bus.ioctl_rd = 1'b1;
    bus.ioctl_addr = 16'h0040;
    tick();
    bus.ioctl_rd = 1'b0;
    bus.ioctl_upload = 1'b0;
    #1;
    chk("drop_req_held", 32'(bus.mem_req), 32'h1);
    chk("drop_no_early_done", 32'(done), 32'h0);
    tick();
    chk("drop_req_held2", 32'(bus.mem_req), 32'h1);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 8'h99;
    tick();
    bus.mem_ack = 1'b0;
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (done) dones++;
      tick();
    end
    chk("drop_done_pulses", 32'(dones), 32'd1);
    chk("drop_din", 32'(bus.ioctl_din), 32'h99);
    bus.ioctl_upload = 1'b1;
    tick();
    bus.ioctl_rd = 1'b1;
    bus.ioctl_addr = 16'h0050;
    tick();
    bus.ioctl_rd = 1'b0;
    chk("rst_mid_req_on", 32'(bus.mem_req), 32'h1);
    reset = 1'b0;
    #1;
    chk("rst_mid_req", 32'(bus.mem_req), 32'h0);
    chk("rst_mid_wait", 32'(bus.ioctl_wait), 32'h0);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    tick();
    reset = 1'b1;
    tick();
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 8'h12;
    tick();
    bus.mem_ack = 1'b0;
    tick();
    chk("late_ack_din", 32'(bus.ioctl_din), 32'h0);
    chk("late_ack_cnt", 32'(byte_count), 32'h0);
    chk("late_ack_busy", 32'(busy), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
